// File: rtl/uport_pkg.sv
// Shared types and constants for the user-port transaction responder.
// Widths of the request sideband fields, FSM state encoding and LFSR seed.
package uport_pkg;
  localparam int UPORT_ID_W   = 11;
  localparam int UPORT_LEN_W  = 8;
  localparam int UPORT_STRB_W = 16;
  localparam logic [15:0] UPORT_LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    WR_DONE,
    RD_BEAT,
    RD_DONE
  } uport_state_e;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } uport_dir_e;
endpackage

// File: rtl/uport_xact_responder_if.sv
// User-port request/beat/completion bundle; master is the initiator, slave the responder.
// All strobes are single-cycle pulses except req, which is held until ack.
interface uport_xact_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  import uport_pkg::*;

  logic [ADDR_W-1:0]       uwr_addr;
  logic                    uwr_req;
  logic [UPORT_STRB_W-1:0] uwr_strb;
  logic [UPORT_ID_W-1:0]   uwr_id;
  logic [UPORT_LEN_W-1:0]  uwr_len;
  logic                    uwr_ack;
  logic                    fifo_rd_en;
  logic [DATA_W-1:0]       fifo_wr_data;
  logic                    uwr_done;
  logic [UPORT_ID_W-1:0]   uwr_resp_id;

  logic [ADDR_W-1:0]       urd_addr;
  logic                    urd_req;
  logic [UPORT_ID_W-1:0]   urd_id;
  logic [UPORT_LEN_W-1:0]  urd_len;
  logic                    urd_ack;
  logic                    fifo_wr_en;
  logic [DATA_W-1:0]       fifo_rd_data;
  logic                    urd_done;
  logic [UPORT_ID_W-1:0]   urd_resp_id;

  modport master (
    output uwr_addr, uwr_req, uwr_strb, uwr_id, uwr_len, fifo_wr_data,
    output urd_addr, urd_req, urd_id, urd_len,
    input  uwr_ack, fifo_rd_en, uwr_done, uwr_resp_id,
    input  urd_ack, fifo_wr_en, fifo_rd_data, urd_done, urd_resp_id
  );

  modport slave (
    input  uwr_addr, uwr_req, uwr_strb, uwr_id, uwr_len, fifo_wr_data,
    input  urd_addr, urd_req, urd_id, urd_len,
    output uwr_ack, fifo_rd_en, uwr_done, uwr_resp_id,
    output urd_ack, fifo_wr_en, fifo_rd_data, urd_done, urd_resp_id
  );
endinterface

// File: rtl/uport_rsp_mem.sv
// Single-port DATA_W x MEM_DEPTH backing store: byte-enable write on clock, combinational read.
// No reset on the array; contents persist across responder resets.
module uport_rsp_mem #(
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         clock,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  output logic [DATA_W-1:0]            rdata
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/uport_xact_responder.sv
// Memory-backed user-port responder: ack at T+1, write done at T+4+len, read done at T+3+len.
// Beat strobes are continuous unless UPORT_RSP_BACKPRESSURE_EN inserts LFSR-driven stalls.
module uport_xact_responder
  import uport_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  uport_xact_responder_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  uport_state_e           state;
  uport_dir_e             last_grant;
  logic [IDX_W-1:0]       idx;
  logic [UPORT_LEN_W-1:0] beat_cnt;
  logic [UPORT_ID_W-1:0]  xact_id;
  logic [BYTES-1:0]       xact_strb;
  logic                   cap_vld;
  logic                   stall;
  logic                   tie;
  logic                   pick_wr;
  logic [ADDR_W-1:0]      req_addr;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   unused_bits;

  assign tie      = bus.uwr_req && bus.urd_req;
  assign pick_wr  = tie ? (last_grant == GNT_RD) : bus.uwr_req;
  assign req_addr = pick_wr ? bus.uwr_addr : bus.urd_addr;
  assign unused_bits = ^{req_addr, bus.uwr_strb};

`ifdef UPORT_RSP_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr <= UPORT_LFSR_SEED;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // Write beats land one cycle after their pop strobe, so cap_vld is fifo_rd_en delayed.
  uport_rsp_mem #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (cap_vld),
    .addr  (idx),
    .wdata (bus.fifo_wr_data),
    .wstrb (xact_strb),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      last_grant       <= GNT_RD;
      idx              <= '0;
      beat_cnt         <= '0;
      xact_id          <= '0;
      xact_strb        <= '0;
      cap_vld          <= 1'b0;
      bus.uwr_ack      <= 1'b0;
      bus.fifo_rd_en   <= 1'b0;
      bus.uwr_done     <= 1'b0;
      bus.uwr_resp_id  <= '0;
      bus.urd_ack      <= 1'b0;
      bus.fifo_wr_en   <= 1'b0;
      bus.fifo_rd_data <= '0;
      bus.urd_done     <= 1'b0;
      bus.urd_resp_id  <= '0;
    end else begin
      bus.uwr_ack  <= 1'b0;
      bus.urd_ack  <= 1'b0;
      bus.uwr_done <= 1'b0;
      bus.urd_done <= 1'b0;
      cap_vld      <= bus.fifo_rd_en;
      if (cap_vld) idx <= idx + 1'b1;

      case (state)
        IDLE: begin
          if (bus.uwr_req || bus.urd_req) begin
            idx       <= req_addr[OFF_W +: IDX_W];
            beat_cnt  <= pick_wr ? bus.uwr_len : bus.urd_len;
            xact_id   <= pick_wr ? bus.uwr_id : bus.urd_id;
            xact_strb <= bus.uwr_strb[BYTES-1:0];
            // Only contested grants move the round-robin pointer.
            if (tie) last_grant <= pick_wr ? GNT_WR : GNT_RD;
            if (pick_wr) begin
              bus.uwr_ack <= 1'b1;
              state       <= WR_BEAT;
            end else begin
              bus.urd_ack <= 1'b1;
              state       <= RD_BEAT;
            end
          end
        end
        WR_BEAT: begin
          if (stall) begin
            bus.fifo_rd_en <= 1'b0;
          end else begin
            bus.fifo_rd_en <= 1'b1;
            if (beat_cnt == '0) state <= WR_DONE;
            else                beat_cnt <= beat_cnt - 1'b1;
          end
        end
        WR_DONE: begin
          bus.fifo_rd_en <= 1'b0;
          // Finish on the capture of the final beat, once no pop is outstanding.
          if (cap_vld && !bus.fifo_rd_en) begin
            bus.uwr_done    <= 1'b1;
            bus.uwr_resp_id <= xact_id;
            state           <= IDLE;
          end
        end
        RD_BEAT: begin
          if (stall) begin
            bus.fifo_wr_en <= 1'b0;
          end else begin
            bus.fifo_wr_en   <= 1'b1;
            bus.fifo_rd_data <= mem_rdata;
            idx              <= idx + 1'b1;
            if (beat_cnt == '0) state <= RD_DONE;
            else                beat_cnt <= beat_cnt - 1'b1;
          end
        end
        RD_DONE: begin
          bus.fifo_wr_en  <= 1'b0;
          bus.urd_done    <= 1'b1;
          bus.urd_resp_id <= xact_id;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uport_xact_responder.sv
// Randomized bench for uport_xact_responder against a word-array memory model.
// Drives and samples on the falling edge; latencies are counted from the req-assert cycle.
module tb_uport_xact_responder;
  localparam int D = 1024;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  uport_xact_responder_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  uport_xact_responder #(.ADDR_W(64), .DATA_W(64), .MEM_DEPTH(D)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [63:0] model [D];
  logic [63:0] wdat [256];
  logic [63:0] rq [$];
  logic [63:0] w_addr, r_addr;
  logic [15:0] w_strb;
  logic [10:0] w_id, r_id;
  logic [7:0]  w_len, r_len;
  bit          lg_wr;
  bit          first_wr;
  int          n_chk, n_pass, nd;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [127:0] outs();
    return {36'd0, bus.uwr_ack, bus.fifo_rd_en, bus.uwr_done, bus.uwr_resp_id,
            bus.urd_ack, bus.fifo_wr_en, bus.urd_done, bus.urd_resp_id, bus.fifo_rd_data};
  endfunction

  function automatic logic [63:0] rbeat(input int j);
    return (j < rq.size()) ? rq[j] : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  task automatic setw(input logic [63:0] a, input int len, input logic [15:0] s, input logic [10:0] id);
    w_addr = a; w_len = 8'(len); w_strb = s; w_id = id;
  endtask

  task automatic setr(input logic [63:0] a, input int len, input logic [10:0] id);
    r_addr = a; r_len = 8'(len); r_id = id;
  endtask

  task automatic fill_rand();
    for (int j = 0; j < 256; j++) wdat[j] = {$urandom, $urandom};
  endtask

  task automatic model_write(input int nb);
    int w;
    for (int j = 0; j < nb; j++) begin
      w = (int'(w_addr[12:3]) + j) % D;
      for (int b = 0; b < 8; b++)
        if (w_strb[b]) model[w][8*b +: 8] = wdat[j][8*b +: 8];
    end
  endtask

  task automatic run_xact(input bit en_w, input bit en_r, input int abort_at);
    int k, wi, n_rd_en, n_ack_w, n_ack_r, n_done_w, n_done_r;
    int ack_w_k, ack_r_k, done_w_k, done_r_k;
    int ew_ack, ew_done, er_ack, er_done;
    bit pend, fin, got_first, exp_wr_first;
    logic [10:0] dw_id, dr_id;
    k = 0; wi = 0; n_rd_en = 0; n_ack_w = 0; n_ack_r = 0; n_done_w = 0; n_done_r = 0;
    ack_w_k = 0; ack_r_k = 0; done_w_k = 0; done_r_k = 0;
    pend = 0; fin = 0; got_first = 0; first_wr = 0; dw_id = '0; dr_id = '0;
    rq.delete();
    @(negedge clock);
    bus.uwr_addr = w_addr; bus.uwr_strb = w_strb; bus.uwr_id = w_id; bus.uwr_len = w_len;
    bus.urd_addr = r_addr; bus.urd_id = r_id; bus.urd_len = r_len;
    bus.uwr_req = en_w; bus.urd_req = en_r;
    while (!fin && k < 3000) begin
      @(negedge clock);
      k++;
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("reset_mid_burst_outs", outs(), '0);
        bus.uwr_req = 1'b0; bus.urd_req = 1'b0;
        fin = 1;
      end else begin
        if (pend) begin bus.fifo_wr_data = wdat[wi & 255]; wi++; end
        pend = bus.fifo_rd_en;
        if (bus.fifo_rd_en) n_rd_en++;
        if (bus.uwr_ack) begin
          n_ack_w++; ack_w_k = k; bus.uwr_req = 1'b0;
          if (!got_first) begin got_first = 1; first_wr = 1; end
        end
        if (bus.urd_ack) begin
          n_ack_r++; ack_r_k = k; bus.urd_req = 1'b0;
          if (!got_first) begin got_first = 1; first_wr = 0; end
        end
        if (bus.fifo_wr_en) rq.push_back(bus.fifo_rd_data);
        if (bus.uwr_done) begin n_done_w++; done_w_k = k; dw_id = bus.uwr_resp_id; end
        if (bus.urd_done) begin n_done_r++; done_r_k = k; dr_id = bus.urd_resp_id; end
        fin = (!en_w || n_done_w > 0) && (!en_r || n_done_r > 0);
      end
    end
    check("xact_finished", fin, 1);
    if (abort_at > 0) begin
      lg_wr = 0;
`ifndef UPORT_RSP_BACKPRESSURE_EN
      // Beats are captured at T+3+j; reset mid-cycle abort_at keeps j < abort_at-3.
      model_write(abort_at - 3);
`endif
      return;
    end

    exp_wr_first = (en_w && en_r) ? !lg_wr : en_w;
    if (en_w && en_r) begin
      check("tie_order", first_wr, exp_wr_first);
      lg_wr = exp_wr_first;
    end
    if (exp_wr_first) begin
      ew_ack = 1; ew_done = ew_ack + 3 + w_len; er_ack = ew_done + 1; er_done = er_ack + 2 + r_len;
    end else begin
      er_ack = 1; er_done = er_ack + 2 + r_len; ew_ack = er_done + 1; ew_done = ew_ack + 3 + w_len;
    end

    if (en_w) begin
      check("wr_ack_count", n_ack_w, 1);
      check("wr_done_count", n_done_w, 1);
      check("wr_resp_id", dw_id, w_id);
      check("rd_en_pulses", n_rd_en, w_len + 1);
`ifndef UPORT_RSP_BACKPRESSURE_EN
      check("wr_ack_cycle", ack_w_k, ew_ack);
      check("wr_done_cycle", done_w_k, ew_done);
`else
      check("wr_ack_cycle_min", ack_w_k >= ew_ack, 1);
      check("wr_done_cycle_min", done_w_k >= ew_done, 1);
`endif
    end
    if (en_r) begin
      check("rd_ack_count", n_ack_r, 1);
      check("rd_done_count", n_done_r, 1);
      check("rd_resp_id", dr_id, r_id);
      check("wr_en_pulses", rq.size(), r_len + 1);
`ifndef UPORT_RSP_BACKPRESSURE_EN
      check("rd_ack_cycle", ack_r_k, er_ack);
      check("rd_done_cycle", done_r_k, er_done);
`else
      check("rd_ack_cycle_min", ack_r_k >= er_ack, 1);
      check("rd_done_cycle_min", done_r_k >= er_done, 1);
`endif
    end

    if (en_w && exp_wr_first) model_write(w_len + 1);
    if (en_r)
      for (int j = 0; j <= int'(r_len); j++)
        check("rd_data", rbeat(j), model[(int'(r_addr[12:3]) + j) % D]);
    if (en_w && !exp_wr_first) model_write(w_len + 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; lg_wr = 0;
    reset_n = 1'b0;
    bus.uwr_addr = '0; bus.uwr_req = 1'b0; bus.uwr_strb = '0; bus.uwr_id = '0; bus.uwr_len = '0;
    bus.urd_addr = '0; bus.urd_req = 1'b0; bus.urd_id = '0; bus.urd_len = '0;
    bus.fifo_wr_data = '0;
    w_addr = '0; r_addr = '0; w_strb = '0; w_id = '0; r_id = '0; w_len = '0; r_len = '0;
    repeat (3) @(negedge clock);
    check("reset_outs_in_reset", outs(), '0);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_outs_after", outs(), '0);

    // Fill the whole store with full-width 256-beat bursts, then read the first block back.
    for (int p = 0; p < 4; p++) begin
      setw(64'(p * 256 * 8), 255, 16'hFFFF, 11'(p));
      fill_rand();
      run_xact(1, 0, 0);
    end
    setr(64'h0, 255, 11'h7);
    run_xact(0, 1, 0);

    setw(64'h100, 3, 16'h00FF, 11'h12);
    for (int j = 0; j < 4; j++) wdat[j] = 64'hA0 + 64'(j);
    run_xact(1, 0, 0);
    setr(64'h100, 3, 11'h12);
    run_xact(0, 1, 0);
    for (int j = 0; j < 4; j++) check("burst_a0_data", rbeat(j), 64'hA0 + 64'(j));

    setw(64'h200, 0, 16'h00FF, 11'h1);
    wdat[0] = 64'h1111_2222_3333_4444;
    run_xact(1, 0, 0);
    setw(64'h200, 0, 16'h000F, 11'h2);
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_xact(1, 0, 0);
    setr(64'h200, 0, 11'h3);
    run_xact(0, 1, 0);
    check("strb_merge", rbeat(0), 64'h1111_2222_FFFF_FFFF);

    setw(64'h300, 1, 16'hFFFF, 11'h21); fill_rand();
    setr(64'h400, 2, 11'h22);
    run_xact(1, 1, 0);
    check("tie1_write_first", first_wr, 1);
    setw(64'h308, 2, 16'h00F0, 11'h23); fill_rand();
    setr(64'h300, 1, 11'h24);
    run_xact(1, 1, 0);
    check("tie2_read_first", first_wr, 0);

    setr(64'((D - 2) * 8), 3, 11'h33);
    run_xact(0, 1, 0);

    setw(64'h500, 7, 16'hFFFF, 11'h44); fill_rand();
    run_xact(1, 0, 4);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.uwr_done) nd++;
    end
    check("no_done_after_abort", nd, 0);
`ifdef UPORT_RSP_BACKPRESSURE_EN
    setw(64'h500, 7, 16'hFFFF, 11'h45); fill_rand();
    run_xact(1, 0, 0);
`endif
    setr(64'h500, 0, 11'h46);
    run_xact(0, 1, 0);
    setr(64'h508, 1, 11'h47);
    run_xact(0, 1, 0);

    for (int it = 0; it < 40; it++) begin
      int mode, wl, rl;
      mode = $urandom_range(0, 2);
      wl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      rl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      setw({$urandom, $urandom}, wl, 16'($urandom), 11'($urandom));
      setr({$urandom, $urandom}, rl, 11'($urandom));
      fill_rand();
      run_xact(mode != 1, mode != 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uport_xact_responder.md
# uport_xact_responder

Memory-backed responder for the user-port (uwr/urd) transaction interface. The bus-side interface drives write and read requests. This block acknowledges them, pulls write beats through the FIFO read strobe, and returns read beats through the FIFO write strobe. It signals completion with a done pulse carrying the request ID. It serves as the far-end model/RTL stub behind the user-port master in SoC-level benches, and as a loopback target for bring-up.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, beat width; legal values 8..128; uses low DATA_W/8 bits of strb
- MEM_DEPTH, 1024, words of DATA_W in backing store; power of two
- clock  input  1  sole clock
- reset_n  input  1  asynchronous, active-low reset
- uwr_addr  input  ADDR_W  write start byte address
- uwr_req  input  1  write request, held until ack
- uwr_strb  input  16  byte enables, applied to every beat of the burst
- uwr_id  input  11  write ID
- uwr_len  input  8  beats minus one
- uwr_ack  output  1  one-cycle write-request accept
- fifo_rd_en  output  1  pop strobe toward initiator write-data FIFO
- fifo_wr_data  input  DATA_W  write beat, valid one cycle after fifo_rd_en
- uwr_done  output  1  one-cycle write completion
- uwr_resp_id  output  11  ID of completing write, valid with uwr_done
- urd_addr  input  ADDR_W  read start byte address
- urd_req  input  1  read request, held until ack
- urd_id  input  11  read ID
- urd_len  input  8  beats minus one
- urd_ack  output  1  one-cycle read-request accept
- fifo_wr_en  output  1  push strobe for read beat
- fifo_rd_data  output  DATA_W  read beat, valid with fifo_wr_en
- urd_done  output  1  one-cycle read completion
- urd_resp_id  output  11  ID of completing read, valid with urd_done

## Operation
- Reset: all outputs 0; FSM to IDLE; last_grant=RD; beat counter 0. Memory contents are not reset.
- FSM states: IDLE, WR_BEAT, WR_DONE, RD_BEAT, RD_DONE. One transaction in flight at a time.
- IDLE transitions:
  - Only uwr_req: pulse uwr_ack; latch addr/len/id/strb; go to WR_BEAT.
  - Only urd_req: mirror of the write case, going to RD_BEAT.
  - Both requests: grant the direction opposite last_grant, then update last_grant. Writes win the first tie after reset.
- Word index = addr[log2(DATA_W/8) +: log2(MEM_DEPTH)]. Low address bits are ignored (aligned beats). Index increments by 1 per beat and wraps modulo MEM_DEPTH.
- WR_BEAT: assert fifo_rd_en for len+1 beats. Each captured fifo_wr_data is written under strb[DATA_W/8-1:0]. After the final capture, go to WR_DONE.
- WR_DONE: uwr_done=1, uwr_resp_id=latched id, for one cycle; then IDLE.
- RD_BEAT: fifo_wr_en=1 with fifo_rd_data=mem[index] for len+1 beats; then RD_DONE.
- RD_DONE: urd_done=1, urd_resp_id=latched id, for one cycle; then IDLE.
- The initiator drops req after seeing ack. The block ignores req outside IDLE.
- len=0: single beat; len=255: 256 beats.
- A reset deassertion mid-burst aborts the burst. No done is issued. Any partial write already stored remains in memory.

## Timing
- req first high at cycle T (FSM in IDLE) -> ack at T+1, registered.
- Write: fifo_rd_en cycles T+2..T+2+len without stalls. Data is captured at T+3..T+3+len. uwr_done is at T+4+len.
- Read: fifo_wr_en cycles T+2..T+2+len. urd_done is at T+3+len.
- Earliest next ack is the cycle after done.
- Read-after-write to the same word returns the new data, because memory is written before done.

## Configuration
- UPORT_RSP_BACKPRESSURE_EN defined: a 16-bit LFSR (seed 16'hACE1, reset-loaded) advances every cycle. When lfsr[0]=1 in WR_BEAT/RD_BEAT, fifo_rd_en/fifo_wr_en are held low and the beat counter stalls.
  - Write capture still occurs exactly one cycle after each asserted fifo_rd_en.
  - Latencies above become lower bounds.
- Macro undefined: no LFSR; the beat strobe is continuous, with the exact latencies above.

## Structure
- uport_pkg: state enum, UPORT_ID_W=11, UPORT_LEN_W=8, UPORT_STRB_W=16, LFSR seed constant.
- Sub-module uport_rsp_mem: single-port DATA_W x MEM_DEPTH array with byte-enable write and combinational read. The FSM, arbiter, counters and LFSR live in the top.

## Test plan
- Write addr=0x100, len=3, strb=0x00FF, id=0x12, data 0xA0..0xA3, then read the same burst -> read beats 0xA0..0xA3; done IDs 0x12; ack at T+1; uwr_done at T+7.
- Write strb=0x000F of 0xFFFF_FFFF_FFFF_FFFF over a word holding 0x1111_2222_3333_4444 -> read returns 0x1111_2222_FFFF_FFFF.
- uwr_req and urd_req asserted in the same cycle, twice -> order is W, R, then R, W on the next tie. Each done carries the correct ID.
- Read addr=(MEM_DEPTH-2)*8, len=3 -> beats from words MEM_DEPTH-2, MEM_DEPTH-1, 0, 1.
- Assert reset_n low during beat 2 of a len=7 write -> all outputs 0 within the same cycle; no uwr_done. A following len=0 read acks at T+1.
- With UPORT_RSP_BACKPRESSURE_EN: len=255 write then read -> exactly 256 fifo_rd_en and 256 fifo_wr_en pulses, with data intact.
